load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential load/store unit between the core's execute stage and the word-addressed, 1024×32 data memory. Converts byte-addressed byte/halfword/word requests into the memory's single-cycle-latency word accesses. Sub-word stores run as read-modify-write; loads are extracted and sign- or zero-extended. Out-of-range and misaligned requests are reported as errors.

## Interface
- MEM_WORDS, 1024: data memory depth in 32-bit words; must be a power of two.
- clk  in  1  rising-edge clock, shared with data memory.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, accepts request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse, no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, reserved size or out-of-range.
- mem_addr  out  32  word index = req_addr >> 2, zero-extended.
- mem_wdata  out  32  word to write.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  32  memory read data, valid the cycle after mem_re; held while mem_re is low.

## Operation
- Request fields are captured on accept (req_valid && req_ready). req_ready = 1 only in IDLE.
- States:
  - IDLE
  - LD_RD: mem_re=1
  - LD_DATA: extract
  - ST_WR: mem_we=1, full word
  - RMW_RD: mem_re=1
  - RMW_WR: mem_we=1, merged word
  - RESP: resp_valid=1
- Transitions on accept:
  - error → RESP
  - load → LD_RD → LD_DATA → RESP
  - word store → ST_WR → RESP
  - byte/half store → RMW_RD → RMW_WR → RESP
  - RESP → IDLE always.
- Errors:
  - size 11
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - out-of-range (see Configuration)
  - An error issues no memory access and returns resp_err=1, resp_rdata=0.
- Lanes are little-endian: byte lane = addr[1:0], bits 8·lane+7:8·lane; halfword lane = addr[1].
- RMW_WR merges combinationally from mem_rdata: only the target lane(s) are replaced by req_wdata[7:0] or [15:0]; the other bytes are preserved.
- In LD_DATA, the lane is extracted from mem_rdata, extended per req_signed, and registered into resp_rdata.
- mem_we and mem_re are decoded from state and gated with !rst. No memory access occurs in a reset cycle.
- A request presented while busy is not accepted; requester holds it.

## Timing
- Accept in cycle 0. resp_valid is high in:
  - cycle 3 for a load
  - cycle 2 for a word store
  - cycle 3 for a sub-word store
  - cycle 1 for an error
- Next accept is possible in the cycle after RESP. Throughput is one request per 2–4 cycles.
- Reset values:
  - state IDLE
  - resp_valid 0, resp_rdata 0, resp_err 0
  - mem_we 0, mem_re 0
  - mem_addr 0, mem_wdata 0
  - req_ready 1 in the cycle after reset.
- Reset mid-operation aborts the transaction. No response is issued. A pending RMW write is dropped, and the memory word is left unchanged.
- resp_rdata and resp_err hold their values until the next response.

## Configuration
- LSU_RANGE_CHECK_EN defined: any address with req_addr[31:log2(MEM_WORDS)+2] ≠ 0 is an error.
- Undefined: those upper bits are ignored, and the address wraps modulo 4·MEM_WORDS bytes. mem_addr carries only the in-range index.

## Structure
- Package lsu_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum
  - MEM_WORDS default.
- Sub-module lsu_lane_align (combinational) performs load extract/extend and store merge. The FSM and registers stay in load_store_unit.

## Test plan
- Memory word 4 = 0x8877_66F5; signed byte load at 0x13 → resp_rdata 0xFFFF_FF88 in cycle 3; unsigned → 0x0000_0088.
- Word store 0xDEAD_BEEF to 0x20 → mem_we with mem_addr 8 in cycle 1; resp_valid cycle 2; subsequent word load returns 0xDEAD_BEEF.
- Word 4 = 0x8877_66F5; halfword store 0x1234 to 0x12 → memory word 4 = 0x1234_66F5; resp_err 0.
- Halfword load at 0x11, word load at 0x2 and size 11 → resp_err 1 in cycle 1, resp_rdata 0, mem_we/mem_re never asserted.
- Byte store to 0x1000 with LSU_RANGE_CHECK_EN: resp_err 1. Without it: byte lands in word 0, lane 0.
- rst asserted during RMW_RD → no mem_we, no resp_valid, req_ready 1 the next cycle, memory word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Size encodings, FSM states and default memory depth.
package lsu_pkg;

  localparam int MEM_WORDS_DEF = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RD,
    S_LD_DATA,
    S_ST_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads
// and lane merge into the read word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  b_sh;
  logic [4:0]  h_sh;
  logic [7:0]  b_v;
  logic [15:0] h_v;

  always_comb begin
    b_sh    = {lane_i, 3'b000};
    h_sh    = {lane_i[1], 4'b0000};
    b_v     = rdata_i[b_sh +: 8];
    h_v     = rdata_i[h_sh +: 16];
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{sext_i & b_v[7]}}, b_v};
        merge_o = rdata_i;
        merge_o[b_sh +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{16{sext_i & h_v[15]}}, h_v};
        merge_o = rdata_i;
        merge_o[h_sh +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store FSM over a word memory.
// Optional LSU_RANGE_CHECK_EN flags addresses beyond the memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e        state_q;
  logic          sext_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   ld_ext;
  logic [31:0]   st_merge;
  logic          req_err;
  logic          oor;
  logic          bad;

  always_comb begin
    bad = (req_size == 2'b11)
       || (req_size == SZ_HALF && req_addr[0])
       || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  end

`ifdef LSU_RANGE_CHECK_EN
  assign oor = |req_addr[31:AW+2];
`else
  // Upper address bits are dropped so addresses wrap.
  logic unused_hi;
  assign unused_hi = |req_addr[31:AW+2];
  assign oor = 1'b0;
`endif

  assign req_err = bad | oor;

  lsu_lane_align u_align (
    .rdata_i (mem_rdata),
    .wdata_i (wdata_q),
    .lane_i  (lane_q),
    .size_i  (size_q),
    .sext_i  (sext_q),
    .load_o  (ld_ext),
    .merge_o (st_merge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sext_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      lane_q  <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            sext_q  <= req_signed;
            size_q  <= req_size;
            lane_q  <= req_addr[1:0];
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            if (req_err) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else if (!req_write) begin
              state_q <= S_LD_RD;
            end else if (req_size == SZ_WORD) begin
              state_q <= S_ST_WR;
            end else begin
              state_q <= S_RMW_RD;
            end
          end
        end
        S_LD_RD:   state_q <= S_LD_DATA;
        S_LD_DATA: begin
          rdata_q <= ld_ext;
          err_q   <= 1'b0;
          state_q <= S_RESP;
        end
        S_ST_WR, S_RMW_WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= S_RESP;
        end
        S_RMW_RD:  state_q <= S_RMW_WR;
        S_RESP:    state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = 32'(idx_q);
  assign mem_wdata  = (state_q == S_RMW_WR) ? st_merge : wdata_q;
  assign mem_re     = !rst && (state_q == S_LD_RD || state_q == S_RMW_RD);
  assign mem_we     = !rst && (state_q == S_ST_WR || state_q == S_RMW_WR);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a
// behavioural 1024x32 single-cycle memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];

  int checks = 0;
  int failures = 0;

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          we_cyc;
  logic [31:0] we_addr;
  logic        re_seen;
  logic        bad_seen;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd);
    lat = 0; rd = '0; er = 1'b0;
    we_cyc = 0; we_addr = '0; re_seen = 1'b0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    chk("ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_we && we_cyc == 0) begin
        we_cyc = k;
        we_addr = mem_addr;
      end
      if (mem_re) re_seen = 1'b1;
      if (resp_valid) begin
        lat = k;
        rd = resp_rdata;
        er = resp_err;
      end
    end
  endtask

  logic [1:0]  esz [3];
  logic [31:0] ead [3];

  initial begin
    esz = '{2'b01, 2'b10, 2'b11};
    ead = '{32'h11, 32'h2, 32'h10};
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8877_66F5);
    chk("pre_lat", 32'(lat), 32'd2);
    chk("pre_mem4", mem[4], 32'h8877_66F5);

    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lbs_lat", 32'(lat), 32'd3);
    chk("lbs_data", rd, 32'hFFFF_FF88);
    chk("lbs_err", 32'(er), 32'd0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lbu_data", rd, 32'h0000_0088);

    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    chk("sw_we_cyc", 32'(we_cyc), 32'd1);
    chk("sw_we_addr", we_addr, 32'd8);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_rdata", rd, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_lat", 32'(lat), 32'd3);

    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD_1234);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_err", 32'(er), 32'd0);
    chk("sh_we_cyc", 32'(we_cyc), 32'd2);
    chk("sh_mem4", mem[4], 32'h1234_66F5);

    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lb0_data", rd, 32'hFFFF_FFF5);
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("lhs_data", rd, 32'hFFFF_BEEF);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lhu_data", rd, 32'h0000_DEAD);

    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, esz[i], 1'b0, ead[i], 32'h0);
      chk($sformatf("err%0d_lat", i), 32'(lat), 32'd1);
      chk($sformatf("err%0d_err", i), 32'(er), 32'd1);
      chk($sformatf("err%0d_rd", i), rd, 32'd0);
      chk($sformatf("err%0d_mem", i),
          {30'd0, we_cyc != 0, re_seen}, 32'd0);
    end

    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h1000, 32'h0000_00A5);
`ifdef LSU_RANGE_CHECK_EN
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_mem0", mem[0], 32'h1122_3344);
`else
    chk("wrap_err", 32'(er), 32'd0);
    chk("wrap_addr", we_addr, 32'd0);
    chk("wrap_mem0", mem[0], 32'h1122_33A5);
`endif

    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_re", 32'(mem_re), 32'd1);
    rst = 1'b1;
    #1 chk("rmw_re_gated", 32'(mem_re), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    bad_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mem_we || resp_valid) bad_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(bad_seen), 32'd0);
    chk("abort_mem4", mem[4], 32'h1234_66F5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
